// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants.
// Used by the writeback stage and its retire counter.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = 16;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PENDING = 2'd1,
    DONE    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_retire_counter.sv
// Retired-instruction counter: enable, wraps modulo 2^CNT_W,
// asynchronous active-high reset.
module wb_retire_counter
  import mips_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/wb_stage.sv
// MEM/WB latch with writeback control, last-write bypass record
// and retired-instruction counter.
module wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic [ADDR_W-1:0] WriteReg_in,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [DATA_W-1:0] Read_data,
  input  logic              stall,
  input  logic              flush,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] Writedata,
  output logic              wb_valid,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_count
);

  wb_state_t         state_q, state_d;
  logic              valid_q, valid_d;
  logic              regwrite_q, regwrite_d;
  logic              memtoreg_q, memtoreg_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              fwd_valid_q, fwd_valid_d;
  logic [ADDR_W-1:0] fwd_reg_q, fwd_reg_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

  logic              retire_en;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    dst_d      = dst_q;
    alu_d      = alu_q;
    rdata_d    = rdata_q;
    if (!stall) begin
      valid_d    = mem_valid & ~flush;
      regwrite_d = RegWrite_in;
      memtoreg_d = MemtoReg_in;
      dst_d      = WriteReg_in;
      alu_d      = ALU_result;
      rdata_d    = Read_data;
      state_d    = valid_d ? PENDING : EMPTY;
    end else begin
      // A held instruction commits once, then parks in DONE.
      case (state_q)
        PENDING: state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  assign RegWrite  = (state_q == PENDING) & regwrite_q
                   & (dst_q != ADDR_W'(REG_ZERO));
  assign WriteReg  = dst_q;
  assign Writedata = memtoreg_q ? rdata_q : alu_q;
  assign wb_valid  = (state_q != EMPTY);

  always_comb begin
    fwd_valid_d = fwd_valid_q;
    fwd_reg_d   = fwd_reg_q;
    fwd_data_d  = fwd_data_q;
    if (RegWrite) begin
      fwd_valid_d = 1'b1;
      fwd_reg_d   = WriteReg;
      fwd_data_d  = Writedata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      dst_q       <= '0;
      alu_q       <= '0;
      rdata_q     <= '0;
      fwd_valid_q <= 1'b0;
      fwd_reg_q   <= '0;
      fwd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      dst_q       <= dst_d;
      alu_q       <= alu_d;
      rdata_q     <= rdata_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_reg_q   <= fwd_reg_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign fwd_valid = fwd_valid_q;
  assign fwd_reg   = fwd_reg_q;
  assign fwd_data  = fwd_data_q;

  assign retire_en = ~stall & (state_q != EMPTY);

  wb_retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire (
    .clk   (clk),
    .rst   (rst),
    .en    (retire_en),
    .count (retire_count)
  );

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline latch plus writeback control for the 5-stage MIPS pipeline.
- Captures each MEM-stage result and selects ALU result or load data (MemtoReg).
- Drives the register file write port (RegWrite, WriteReg, Writedata), which the register file commits on posedge clk.
- Also provides a last-written bypass record for EX forwarding and a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, register index width.
- CNT_W, 16, retire counter width.

Ports:
- clk  input  1  pipeline clock, all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- mem_valid  input  1  MEM stage holds a real instruction.
- RegWrite_in  input  1  instruction writes a register.
- MemtoReg_in  input  1  1 selects Read_data, 0 selects ALU_result.
- WriteReg_in  input  ADDR_W  destination register.
- ALU_result  input  DATA_W  ALU result from MEM stage.
- Read_data  input  DATA_W  data memory load result.
- stall  input  1  hold WB latch contents.
- flush  input  1  kill instruction being captured.
- RegWrite  output  1  register file write enable.
- WriteReg  output  ADDR_W  register file write index.
- Writedata  output  DATA_W  register file write data.
- wb_valid  output  1  WB latch holds a real instruction.
- fwd_valid  output  1  fwd_reg/fwd_data hold a completed write.
- fwd_reg  output  ADDR_W  index of last completed write.
- fwd_data  output  DATA_W  data of last completed write.
- retire_count  output  CNT_W  instructions retired since reset.

Behaviour:
- Reset (async, immediate): state=EMPTY; latch fields 0; RegWrite=0; WriteReg=0; Writedata=0; wb_valid=0; fwd_valid=0; fwd_reg=0; fwd_data=0; retire_count=0.
- Latch fields: valid, regwrite, memtoreg, dst, alu, rdata. Writedata = memtoreg ? rdata : alu, a combinational mux off the latch. WriteReg = dst.
- State machine:
  - EMPTY: no instruction held.
  - PENDING: instruction held, write not yet committed.
  - DONE: instruction held under stall, write already committed.
- RegWrite = (state==PENDING) & regwrite & (dst!=0). Writes to $0 are always suppressed but the instruction still retires.
- wb_valid = (state != EMPTY).
- Each posedge, stall=0:
  - Capture MEM inputs. Next state is PENDING if mem_valid & ~flush, else EMPTY with latch valid cleared.
  - If state was PENDING or DONE, retire_count increments by 1, wrapping modulo 2^CNT_W.
- Each posedge, stall=1:
  - Latch held.
  - PENDING goes to DONE, so the write is issued exactly once.
  - DONE stays DONE. EMPTY stays EMPTY.
  - No retire increment. flush is ignored while stall=1.
- Latency: fields captured at edge N; RegWrite high during cycle N..N+1; register file commits at edge N+1.
- Forwarding: at any posedge where RegWrite=1, fwd_valid<=1, fwd_reg<=WriteReg, fwd_data<=Writedata. Otherwise fwd_* hold.
- Simultaneous flush and mem_valid with stall=0: flush wins, giving EMPTY. The currently held instruction still retires.
- Reset asserted mid-write: RegWrite drops to 0 asynchronously, the pending write is lost, and the counter clears.

Decomposition:
- Shared package `mips_pkg` holds:
  - wb_state_t enum (EMPTY=2'd0, PENDING=2'd1, DONE=2'd2).
  - REG_ZERO=5'd0.
  - DATA_W/ADDR_W defaults.
- One natural sub-module: `wb_retire_counter` (enable, wrap, async reset). Everything else stays inline.

Test Plan:
- Reset, then mem_valid=1, RegWrite_in=1, MemtoReg_in=0, WriteReg_in=5'd8, ALU_result=32'h0000_1234, one edge. Required next cycle: RegWrite=1, WriteReg=8, Writedata=32'h0000_1234, wb_valid=1. Following edge: fwd_valid=1, fwd_reg=8, fwd_data=32'h1234, retire_count=1.
- Load: MemtoReg_in=1, Read_data=32'hDEAD_BEEF, ALU_result=32'h0000_0040, WriteReg_in=5'd9 -> Writedata=32'hDEADBEEF.
- WriteReg_in=0, RegWrite_in=1 -> RegWrite stays 0 and fwd_* unchanged. retire_count still increments on the next edge.
- Capture dst=5'd3, then stall=1 for 3 edges -> RegWrite=1 only in the first cycle and 0 in the 3 stalled cycles after; wb_valid=1 throughout; retire_count unchanged until stall drops, then +1.
- flush=1 with mem_valid=1, stall=0 -> next cycle wb_valid=0, RegWrite=0. Also: stall=1, flush=1 -> latch held and flush ignored.
- Preload retire_count to 16'hFFFF via 65535 retirements, one more -> 16'h0000. Assert rst while RegWrite=1 -> RegWrite=0 and all outputs 0 immediately, without waiting for a clock edge.
